// File: rtl/mem_to_axi_master.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | mem_to_axi_master: req/gnt/rvalid memory port to single-beat AXI4 manager  |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+

package core_v_mcu_pkg;
   localparam int unsigned AXI_ADDR_WIDTH = 32;
   localparam int unsigned AXI_DATA_WIDTH = 64;
   localparam int unsigned AXI_ID_WIDTH   = 4;
   localparam int unsigned AXI_USER_WIDTH = 1;

   typedef struct packed {
      logic [AXI_ID_WIDTH-1:0]   id;
      logic [AXI_ADDR_WIDTH-1:0] addr;
      logic [7:0]                len;
      logic [2:0]                size;
      logic [1:0]                burst;
      logic                      lock;
      logic [3:0]                cache;
      logic [2:0]                prot;
      logic [3:0]                qos;
      logic [3:0]                region;
      logic [5:0]                atop;
      logic [AXI_USER_WIDTH-1:0] user;
   } axi_aw_chan_t;

   typedef struct packed {
      logic [AXI_ID_WIDTH-1:0]   id;
      logic [AXI_ADDR_WIDTH-1:0] addr;
      logic [7:0]                len;
      logic [2:0]                size;
      logic [1:0]                burst;
      logic                      lock;
      logic [3:0]                cache;
      logic [2:0]                prot;
      logic [3:0]                qos;
      logic [3:0]                region;
      logic [AXI_USER_WIDTH-1:0] user;
   } axi_ar_chan_t;

   typedef struct packed {
      logic [AXI_DATA_WIDTH-1:0]   data;
      logic [AXI_DATA_WIDTH/8-1:0] strb;
      logic                        last;
      logic [AXI_USER_WIDTH-1:0]   user;
   } axi_w_chan_t;

   typedef struct packed {
      logic [AXI_ID_WIDTH-1:0]   id;
      logic [1:0]                resp;
      logic [AXI_USER_WIDTH-1:0] user;
   } axi_b_chan_t;

   typedef struct packed {
      logic [AXI_ID_WIDTH-1:0]   id;
      logic [AXI_DATA_WIDTH-1:0] data;
      logic [1:0]                resp;
      logic                      last;
      logic [AXI_USER_WIDTH-1:0] user;
   } axi_r_chan_t;

   typedef struct packed {
      axi_aw_chan_t aw;
      logic         aw_valid;
      axi_w_chan_t  w;
      logic         w_valid;
      logic         b_ready;
      axi_ar_chan_t ar;
      logic         ar_valid;
      logic         r_ready;
   } axi_mst_req_t;

   typedef struct packed {
      logic        aw_ready;
      logic        ar_ready;
      logic        w_ready;
      logic        b_valid;
      axi_b_chan_t b;
      logic        r_valid;
      axi_r_chan_t r;
   } axi_mst_rsp_t;
endpackage

module mem_to_axi_master #(
   parameter int unsigned AddrWidth = 32,
   parameter logic [core_v_mcu_pkg::AXI_ID_WIDTH-1:0] IdValue = '0,
   parameter logic [3:0] AxCache = 4'b0010,
   parameter logic [2:0] AxProt  = 3'b000
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          mem_req_i,
   output logic                          mem_gnt_o,
   input  logic [AddrWidth-1:0]          mem_addr_i,
   input  logic                          mem_we_i,
   input  logic [63:0]                   mem_wdata_i,
   input  logic [7:0]                    mem_be_i,
   output logic                          mem_rvalid_o,
   output logic [63:0]                   mem_rdata_o,
   output logic                          mem_err_o,
   output core_v_mcu_pkg::axi_mst_req_t  axi_req_o,
   input  core_v_mcu_pkg::axi_mst_rsp_t  axi_rsp_i
);
   import core_v_mcu_pkg::*;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WR_REQ = 3'd1,
      WR_RSP = 3'd2,
      RD_REQ = 3'd3,
      RD_RSP = 3'd4
   } state_e;

   state_e                    r_state, w_state_next;
   logic [AddrWidth-1:0]      r_addr;
   logic [63:0]               r_wdata;
   logic [7:0]                r_be;
   logic                      r_aw_done, r_w_done;
   logic                      r_rvalid, r_err;
   logic [63:0]               r_rdata;
   logic [AXI_ADDR_WIDTH-1:0] w_axi_addr;
   logic                      w_aw_valid, w_w_valid;
   logic                      w_aw_fin, w_w_fin;
   logic                      w_b_hs, w_r_hs;
   logic                      w_unused;

   generate
      if (AddrWidth >= AXI_ADDR_WIDTH) begin : g_addr_trunc
         assign w_axi_addr = r_addr[AXI_ADDR_WIDTH-1:0];
      end else begin : g_addr_ext
         assign w_axi_addr = {{(AXI_ADDR_WIDTH-AddrWidth){1'b0}}, r_addr};
      end
   endgenerate

   // AXI valids decode purely from registered state, never from ready inputs
   assign w_aw_valid = (r_state == WR_REQ) && !r_aw_done;
   assign w_w_valid  = (r_state == WR_REQ) && !r_w_done;
   assign w_aw_fin   = r_aw_done || (w_aw_valid && axi_rsp_i.aw_ready);
   assign w_w_fin    = r_w_done  || (w_w_valid  && axi_rsp_i.w_ready);
   assign w_b_hs     = (r_state == WR_RSP) && axi_rsp_i.b_valid;
   assign w_r_hs     = (r_state == RD_RSP) && axi_rsp_i.r_valid;

   assign mem_gnt_o    = (r_state == IDLE) && mem_req_i;
   assign mem_rvalid_o = r_rvalid;
   assign mem_err_o    = r_err;
   assign mem_rdata_o  = r_rdata;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_state <= IDLE;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (mem_req_i) w_state_next = mem_we_i ? WR_REQ : RD_REQ;
         WR_REQ:  if (w_aw_fin && w_w_fin) w_state_next = WR_RSP;
         WR_RSP:  if (axi_rsp_i.b_valid) w_state_next = IDLE;
         RD_REQ:  if (axi_rsp_i.ar_ready) w_state_next = RD_RSP;
         RD_RSP:  if (axi_rsp_i.r_valid) w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_addr    <= '0;
         r_wdata   <= '0;
         r_be      <= '0;
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
         r_rvalid  <= 1'b0;
         r_err     <= 1'b0;
         r_rdata   <= '0;
      end else begin
         if (mem_gnt_o) begin
            r_addr  <= mem_addr_i;
            r_wdata <= mem_wdata_i;
            r_be    <= mem_be_i;
         end
         if (r_state == IDLE) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
         end else if (r_state == WR_REQ) begin
            r_aw_done <= w_aw_fin;
            r_w_done  <= w_w_fin;
         end
         r_rvalid <= w_b_hs || w_r_hs;
         r_err    <= (w_b_hs && axi_rsp_i.b.resp[1]) || (w_r_hs && axi_rsp_i.r.resp[1]);
         if (w_r_hs) r_rdata <= axi_rsp_i.r.data;
      end
   end

   always_comb begin
      axi_req_o           = '0;
      axi_req_o.aw.id     = IdValue;
      axi_req_o.aw.addr   = w_axi_addr;
      axi_req_o.aw.size   = 3'b011;
      axi_req_o.aw.burst  = 2'b01;
      axi_req_o.aw.cache  = AxCache;
      axi_req_o.aw.prot   = AxProt;
      axi_req_o.aw_valid  = w_aw_valid;
      axi_req_o.w.data    = r_wdata;
      axi_req_o.w.strb    = r_be;
      axi_req_o.w.last    = 1'b1;
      axi_req_o.w_valid   = w_w_valid;
      axi_req_o.b_ready   = (r_state == WR_RSP);
      axi_req_o.ar.id     = IdValue;
      axi_req_o.ar.addr   = w_axi_addr;
      axi_req_o.ar.size   = 3'b011;
      axi_req_o.ar.burst  = 2'b01;
      axi_req_o.ar.cache  = AxCache;
      axi_req_o.ar.prot   = AxProt;
      axi_req_o.ar_valid  = (r_state == RD_REQ);
      axi_req_o.r_ready   = (r_state == RD_RSP);
   end

   // Response IDs, user bits and r.last carry no information with one outstanding beat
   assign w_unused = ^{axi_rsp_i.b.id, axi_rsp_i.b.user, axi_rsp_i.b.resp[0],
                       axi_rsp_i.r.id, axi_rsp_i.r.user, axi_rsp_i.r.resp[0], axi_rsp_i.r.last};
endmodule

`default_nettype wire

// File: tb/tb_mem_to_axi_master.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_mem_to_axi_master: directed and random transactions against a model    |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tb_mem_to_axi_master;
   import core_v_mcu_pkg::*;

   logic         clk_i = 1'b0;
   logic         rst_i = 1'b1;
   logic         mem_req_i = 1'b0;
   logic         mem_gnt_o;
   logic [31:0]  mem_addr_i = '0;
   logic         mem_we_i = 1'b0;
   logic [63:0]  mem_wdata_i = '0;
   logic [7:0]   mem_be_i = '0;
   logic         mem_rvalid_o;
   logic [63:0]  mem_rdata_o;
   logic         mem_err_o;
   axi_mst_req_t axi_req;
   axi_mst_rsp_t axi_rsp = '0;

   int           n_vec = 0;
   int           n_err = 0;
   logic [63:0]  m_last_rdata = '0;

   mem_to_axi_master dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .mem_req_i   (mem_req_i),
      .mem_gnt_o   (mem_gnt_o),
      .mem_addr_i  (mem_addr_i),
      .mem_we_i    (mem_we_i),
      .mem_wdata_i (mem_wdata_i),
      .mem_be_i    (mem_be_i),
      .mem_rvalid_o(mem_rvalid_o),
      .mem_rdata_o (mem_rdata_o),
      .mem_err_o   (mem_err_o),
      .axi_req_o   (axi_req),
      .axi_rsp_i   (axi_rsp)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic scramble_mem_inputs();
      mem_addr_i  = $urandom;
      mem_wdata_i = {$urandom, $urandom};
      mem_be_i    = 8'($urandom);
   endtask

   task automatic idle_cycle();
      tick();
      mem_req_i = 1'b0;
      settle();
      chk("idle_rvalid", mem_rvalid_o, 0);
      chk("idle_valids", {axi_req.aw_valid, axi_req.w_valid, axi_req.ar_valid}, 0);
   endtask

   // Leaves the bench in the cycle where mem_rvalid_o is high
   task automatic do_read(input logic [31:0] addr, input logic [63:0] data, input logic [1:0] resp,
                          input int ar_dly, input int r_dly, input bit probe);
      mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = addr;
      mem_wdata_i = {$urandom, $urandom}; mem_be_i = 8'($urandom);
      settle();
      chk("rd_gnt", mem_gnt_o, 1);
      tick();
      mem_req_i = 1'b0;
      scramble_mem_inputs();
      for (int c = 0; c <= ar_dly; c++) begin
         axi_rsp.ar_ready = (c == ar_dly);
         mem_req_i = probe && (c < ar_dly);
         mem_we_i  = 1'b1;
         settle();
         chk("ar_valid", axi_req.ar_valid, 1);
         chk("ar_addr", axi_req.ar.addr, addr);
         chk("ar_len_size_burst", {axi_req.ar.len, axi_req.ar.size, axi_req.ar.burst}, {8'd0, 3'd3, 2'd1});
         chk("ar_id_cache_prot", {axi_req.ar.id, axi_req.ar.cache, axi_req.ar.prot}, {4'd0, 4'b0010, 3'd0});
         chk("rd_no_aw_w", {axi_req.aw_valid, axi_req.w_valid, axi_req.r_ready}, 0);
         if (probe) chk("busy_gnt", mem_gnt_o, 0);
         tick();
      end
      axi_rsp.ar_ready = 1'b0;
      mem_req_i = 1'b0;
      for (int c = 0; c <= r_dly; c++) begin
         axi_rsp.r_valid = (c == r_dly);
         axi_rsp.r.data  = (c == r_dly) ? data : {$urandom, $urandom};
         axi_rsp.r.resp  = resp;
         axi_rsp.r.last  = 1'b1;
         settle();
         chk("r_ready", axi_req.r_ready, 1);
         chk("rd_wait_valids", {axi_req.ar_valid, mem_rvalid_o}, 0);
         tick();
      end
      axi_rsp.r_valid = 1'b0;
      axi_rsp.r.data  = {$urandom, $urandom};
      m_last_rdata    = data;
      settle();
      chk("rd_rvalid", mem_rvalid_o, 1);
      chk("rd_rdata", mem_rdata_o, m_last_rdata);
      chk("rd_err", mem_err_o, resp[1]);
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [63:0] data, input logic [7:0] be,
                           input int aw_dly, input int w_dly, input int b_dly, input logic [1:0] resp);
      int n;
      n = (aw_dly > w_dly) ? aw_dly : w_dly;
      mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = addr; mem_wdata_i = data; mem_be_i = be;
      settle();
      chk("wr_gnt", mem_gnt_o, 1);
      tick();
      mem_req_i = 1'b0;
      scramble_mem_inputs();
      for (int c = 0; c <= n; c++) begin
         axi_rsp.aw_ready = (c == aw_dly);
         axi_rsp.w_ready  = (c == w_dly);
         settle();
         chk("aw_valid", axi_req.aw_valid, 64'(c <= aw_dly));
         chk("w_valid", axi_req.w_valid, 64'(c <= w_dly));
         if (c <= aw_dly) begin
            chk("aw_addr", axi_req.aw.addr, addr);
            chk("aw_len_size_burst", {axi_req.aw.len, axi_req.aw.size, axi_req.aw.burst}, {8'd0, 3'd3, 2'd1});
         end
         if (c <= w_dly) begin
            chk("w_data", axi_req.w.data, data);
            chk("w_strb_last", {axi_req.w.strb, axi_req.w.last}, {be, 1'b1});
         end
         chk("wr_no_b_ar", {axi_req.b_ready, axi_req.ar_valid}, 0);
         tick();
      end
      axi_rsp.aw_ready = 1'b0;
      axi_rsp.w_ready  = 1'b0;
      for (int c = 0; c <= b_dly; c++) begin
         axi_rsp.b_valid = (c == b_dly);
         axi_rsp.b.resp  = resp;
         settle();
         chk("b_ready", axi_req.b_ready, 1);
         chk("wr_rsp_quiet", {axi_req.aw_valid, axi_req.w_valid, mem_rvalid_o}, 0);
         tick();
      end
      axi_rsp.b_valid = 1'b0;
      settle();
      chk("wr_rvalid", mem_rvalid_o, 1);
      chk("wr_err", mem_err_o, resp[1]);
      chk("wr_rdata_hold", mem_rdata_o, m_last_rdata);
   endtask

   initial begin
      #2;
      chk("rst_outputs", {mem_gnt_o, mem_rvalid_o, mem_err_o, axi_req.aw_valid, axi_req.w_valid,
                          axi_req.ar_valid, axi_req.b_ready, axi_req.r_ready}, 0);
      chk("rst_rdata", mem_rdata_o, 0);
      tick();
      tick();
      rst_i = 1'b0;
      idle_cycle();

      do_read(32'h0000_1000, 64'hDEAD_BEEF_CAFE_F00D, 2'b00, 0, 2, 1'b0);
      idle_cycle();
      do_write(32'h0000_2008, 64'h0123_4567_89AB_CDEF, 8'h0F, 1, 0, 1, 2'b00);
      idle_cycle();
      do_write(32'h0000_3010, 64'h1111_2222_3333_4444, 8'hFF, 0, 0, 0, 2'b10);
      idle_cycle();
      do_write(32'h0000_3018, 64'h5555_6666_7777_8888, 8'h00, 2, 3, 0, 2'b00);
      idle_cycle();

      // back-to-back: next request presented in the rvalid cycle
      do_read(32'h0000_4000, 64'hA5A5_5A5A_0F0F_F0F0, 2'b01, 1, 0, 1'b0);
      do_write(32'h0000_4008, 64'hFEDC_BA98_7654_3210, 8'hC3, 0, 1, 2, 2'b11);
      do_read(32'h0000_4010, 64'h0BAD_F00D_1234_5678, 2'b00, 0, 0, 1'b0);
      idle_cycle();

      do_read(32'h0000_5000, 64'h1357_9BDF_2468_ACE0, 2'b00, 10, 1, 1'b1);
      idle_cycle();

      // asynchronous reset in the middle of a write
      mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h6000;
      mem_wdata_i = 64'h99; mem_be_i = 8'hFF;
      tick();
      mem_req_i = 1'b0;
      settle();
      chk("pre_rst_aw_valid", axi_req.aw_valid, 1);
      rst_i = 1'b1;
      #1;
      m_last_rdata = '0;
      chk("async_rst_valids", {axi_req.aw_valid, axi_req.w_valid, axi_req.ar_valid,
                               axi_req.b_ready, axi_req.r_ready, mem_rvalid_o, mem_err_o}, 0);
      chk("async_rst_rdata", mem_rdata_o, 0);
      tick();
      rst_i = 1'b0;
      tick();
      do_read(32'h0000_7000, 64'hC0FF_EE00_DEAD_0001, 2'b11, 0, 0, 1'b0);
      idle_cycle();

      for (int i = 0; i < 30; i++) begin
         logic [31:0] a;
         logic [63:0] d;
         a = $urandom & 32'hFFFF_FFF8;
         d = {$urandom, $urandom};
         if ($urandom_range(0, 1) == 1)
            do_write(a, d, 8'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3), 2'($urandom));
         else
            do_read(a, d, 2'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                    1'($urandom_range(0, 1)));
         if ($urandom_range(0, 1) == 1) idle_cycle();
      end
      idle_cycle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

`default_nettype wire
